// File: rtl/tse_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// master: the side that supplies lock, acknowledges and software requests.
// slave:  the sequencer, which returns per-stage resets and status flags.
interface tse_reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  pll_locked;
  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] reset_out;
  logic                  seq_done;
  logic                  seq_error;

  modport master (
    output pll_locked,
    output sw_reset_req,
    output stage_ack,
    input  reset_out,
    input  seq_done,
    input  seq_error
  );

  modport slave (
    input  pll_locked,
    input  sw_reset_req,
    input  stage_ack,
    output reset_out,
    output seq_done,
    output seq_error
  );
endinterface

// File: rtl/tse_reset_sequencer.sv
// Ordered reset-release sequencer for the TSE reset domains.
// Holds every domain in reset, waits for PLL lock, then releases stage 0,
// 1, ... in order, waiting for each stage's ready acknowledge and a fixed
// gap before moving on. Lock loss or a software request re-asserts all
// resets; an acknowledge timeout parks the block in ERROR until software
// requests a restart.
module tse_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int SYNC_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset_in,
  tse_reset_sequencer_if.slave    bus
);

  localparam int CNT_MAX = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_STAGES);

  localparam logic [CNT_W-1:0]      GAP_LOAD = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]      ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [NUM_STAGES-1:0] ALL_RST  = '1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  // Synchronizer chains: element [0] samples the raw input,
  // element [SYNC_DEPTH-1] is the version the FSM uses.
  logic [SYNC_DEPTH-1:0] lock_sync_q;
  logic [NUM_STAGES-1:0] ack_sync_q [SYNC_DEPTH];

  logic                  lock_s;
  logic [NUM_STAGES-1:0] ack_s;
  logic                  ack_cur;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] reset_out_q;
  logic                  seq_done_q;
  logic                  seq_error_q;

  // Bring the asynchronous lock and acknowledge inputs into the clk domain.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      lock_sync_q <= '0;
      for (int d = 0; d < SYNC_DEPTH; d++) begin
        ack_sync_q[d] <= '0;
      end
    end else begin
      lock_sync_q   <= {lock_sync_q[SYNC_DEPTH-2:0], bus.pll_locked};
      ack_sync_q[0] <= bus.stage_ack;
      for (int d = 1; d < SYNC_DEPTH; d++) begin
        ack_sync_q[d] <= ack_sync_q[d-1];
      end
    end
  end

  assign lock_s  = lock_sync_q[SYNC_DEPTH-1];
  assign ack_s   = ack_sync_q[SYNC_DEPTH-1];
  // Only the stage currently being released is listened to.
  assign ack_cur = ack_s[idx_q];

  // Sequencer FSM with registered reset and status outputs.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= S_HOLD;
      cnt_q       <= GAP_LOAD;
      idx_q       <= '0;
      reset_out_q <= ALL_RST;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else if (bus.sw_reset_req) begin
      // Software restart wins everywhere, including ERROR and HOLD
      // (where it simply restarts the hold count).
      state_q     <= S_HOLD;
      cnt_q       <= GAP_LOAD;
      idx_q       <= '0;
      reset_out_q <= ALL_RST;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else if (!lock_s && (state_q inside {S_RELEASE, S_WAIT_ACK, S_GAP, S_DONE})) begin
      // Lock loss once release has begun: drop everything back into reset.
      // seq_error is already 0 in these states and is left alone.
      state_q     <= S_HOLD;
      cnt_q       <= GAP_LOAD;
      idx_q       <= '0;
      reset_out_q <= ALL_RST;
      seq_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            idx_q   <= '0;
            state_q <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Stages are only ever released in ascending order, so clearing
          // the single bit at idx keeps the lower-before-higher ordering.
          reset_out_q[idx_q] <= 1'b0;
          cnt_q              <= ACK_LOAD;
          state_q            <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // Acknowledge is tested first so that an ack arriving on the
          // final count still counts as success.
          if (ack_cur) begin
            if (idx_q == LAST_IDX) begin
              seq_done_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              idx_q   <= idx_q + IDX_ONE;
              cnt_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end
          end else if (cnt_q == '0) begin
            reset_out_q <= ALL_RST;
            seq_done_q  <= 1'b0;
            seq_error_q <= 1'b1;
            state_q     <= S_ERROR;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        S_DONE: begin
          // Lock loss is handled above; otherwise remain fully released.
          seq_done_q <= 1'b1;
        end

        S_ERROR: begin
          // Parked with every domain in reset; lock is deliberately ignored
          // and only a software request leaves this state.
          reset_out_q <= ALL_RST;
          seq_done_q  <= 1'b0;
          seq_error_q <= 1'b1;
        end

        default: begin
          state_q     <= S_HOLD;
          cnt_q       <= GAP_LOAD;
          idx_q       <= '0;
          reset_out_q <= ALL_RST;
          seq_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reset_out = reset_out_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_error = seq_error_q;

endmodule

// File: tb/tb_tse_reset_sequencer.sv
// Directed bench for tse_reset_sequencer with default parameters
// (3 stages, 8-cycle hold/gap, 64-cycle ack timeout, 2-flop synchronizers).
module tb_tse_reset_sequencer;

  logic clk      = 1'b0;
  logic reset_in = 1'b1;

  always #5 clk = ~clk;

  tse_reset_sequencer_if #(.NUM_STAGES(3)) bus ();

  tse_reset_sequencer #(
    .NUM_STAGES (3),
    .STAGE_DELAY(8),
    .ACK_TIMEOUT(64),
    .SYNC_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus)
  );

  typedef struct {
    int         edge_n;
    logic       lock;
    logic [2:0] ack;
    logic [2:0] exp_rst;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t tbl [16];

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic go_to(input int target);
    if (target > edge_n) tick(target - edge_n);
  endtask

  // Hold reset for two edges, then release it between edges; edge 0 is
  // the release point.
  task automatic do_reset(input logic lock, input logic [2:0] ack);
    reset_in         = 1'b1;
    bus.sw_reset_req = 1'b0;
    bus.pll_locked   = lock;
    bus.stage_ack    = ack;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_in = 1'b0;
    edge_n   = 0;
  endtask

  task automatic chk(input string name, input logic [2:0] e_rst,
                     input logic e_done, input logic e_err);
    checks++;
    if (bus.reset_out !== e_rst || bus.seq_done !== e_done || bus.seq_error !== e_err) begin
      errors++;
      $display("FAIL %s edge=%0d: got rst=%b done=%b err=%b, expected rst=%b done=%b err=%b",
               name, edge_n, bus.reset_out, bus.seq_done, bus.seq_error,
               e_rst, e_done, e_err);
    end
  endtask

  initial begin
    logic       ok;
    logic [2:0] r;

    bus.pll_locked   = 1'b0;
    bus.sw_reset_req = 1'b0;
    bus.stage_ack    = 3'b000;

    // Boot, lock loss in DONE at edge 41, relock and full re-sequence.
    tbl[0]  = '{0,  1'b1, 3'b111, 3'b111, 1'b0, 1'b0};
    tbl[1]  = '{9,  1'b1, 3'b111, 3'b111, 1'b0, 1'b0};
    tbl[2]  = '{10, 1'b1, 3'b111, 3'b110, 1'b0, 1'b0};
    tbl[3]  = '{19, 1'b1, 3'b111, 3'b110, 1'b0, 1'b0};
    tbl[4]  = '{20, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{29, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0};
    tbl[6]  = '{30, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{31, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0};
    tbl[8]  = '{40, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0};
    tbl[9]  = '{42, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0};
    tbl[10] = '{43, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0};
    tbl[11] = '{52, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0};
    tbl[12] = '{53, 1'b1, 3'b111, 3'b110, 1'b0, 1'b0};
    tbl[13] = '{63, 1'b1, 3'b111, 3'b100, 1'b0, 1'b0};
    tbl[14] = '{73, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0};
    tbl[15] = '{74, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0};

    do_reset(1'b1, 3'b111);
    for (int k = 0; k < 16; k++) begin
      bus.pll_locked = tbl[k].lock;
      bus.stage_ack  = tbl[k].ack;
      go_to(tbl[k].edge_n);
      chk($sformatf("boot_tbl[%0d]", k), tbl[k].exp_rst, tbl[k].exp_done, tbl[k].exp_err);
    end

    // Delayed lock: rise after edge 50, stage 0 released 4 edges later.
    do_reset(1'b0, 3'b111);
    go_to(50);
    chk("dlock_wait", 3'b111, 1'b0, 1'b0);
    bus.pll_locked = 1'b1;
    go_to(53);
    chk("dlock_53", 3'b111, 1'b0, 1'b0);
    go_to(54);
    chk("dlock_54", 3'b110, 1'b0, 1'b0);

    // Ack timeout on stage 1 (stage 2 ack high but ignored).
    do_reset(1'b1, 3'b101);
    go_to(20);
    chk("to_rel1", 3'b100, 1'b0, 1'b0);
    go_to(83);
    chk("to_83", 3'b100, 1'b0, 1'b0);
    go_to(84);
    chk("to_84", 3'b111, 1'b0, 1'b1);
    bus.pll_locked = 1'b0;
    go_to(90);
    chk("to_lock_lo", 3'b111, 1'b0, 1'b1);
    bus.pll_locked = 1'b1;
    go_to(96);
    chk("to_lock_hi", 3'b111, 1'b0, 1'b1);
    bus.sw_reset_req = 1'b1;
    go_to(97);
    bus.sw_reset_req = 1'b0;
    chk("to_swclr", 3'b111, 1'b0, 1'b0);
    go_to(106);
    chk("to_hold_106", 3'b111, 1'b0, 1'b0);
    go_to(107);
    chk("to_rel0_107", 3'b110, 1'b0, 1'b0);
    go_to(181);
    chk("to_again_181", 3'b111, 1'b0, 1'b1);
    // Async reset out of ERROR, no clock edge.
    #3;
    reset_in = 1'b1;
    #1;
    chk("async_err", 3'b111, 1'b0, 1'b0);

    // Ack reaching the FSM on the final count wins over the timeout.
    do_reset(1'b1, 3'b101);
    go_to(81);
    bus.stage_ack = 3'b111;
    go_to(84);
    chk("ackwin_84", 3'b100, 1'b0, 1'b0);
    go_to(92);
    chk("ackwin_92", 3'b100, 1'b0, 1'b0);
    go_to(93);
    chk("ackwin_93", 3'b000, 1'b0, 1'b0);
    go_to(94);
    chk("ackwin_94", 3'b000, 1'b1, 1'b0);

    // Software reset in GAP (idx=2), then again in HOLD to restart the count.
    do_reset(1'b1, 3'b111);
    go_to(24);
    chk("swgap_pre", 3'b100, 1'b0, 1'b0);
    bus.sw_reset_req = 1'b1;
    go_to(25);
    bus.sw_reset_req = 1'b0;
    chk("swgap", 3'b111, 1'b0, 1'b0);
    go_to(29);
    bus.sw_reset_req = 1'b1;
    go_to(30);
    bus.sw_reset_req = 1'b0;
    chk("swhold", 3'b111, 1'b0, 1'b0);
    go_to(35);
    chk("swhold_35", 3'b111, 1'b0, 1'b0);
    go_to(39);
    chk("swhold_39", 3'b111, 1'b0, 1'b0);
    go_to(40);
    chk("swhold_40", 3'b110, 1'b0, 1'b0);
    go_to(61);
    chk("sw_done_61", 3'b000, 1'b1, 1'b0);
    // Async reset mid-DONE, no clock edge.
    #3;
    reset_in = 1'b1;
    #1;
    chk("async_done", 3'b111, 1'b0, 1'b0);

    // Random lock/ack/sw activity: ordering and status consistency.
    do_reset(1'b1, 3'b111);
    for (int c = 0; c < 1000; c++) begin
      bus.pll_locked   = ($urandom_range(0, 19) != 0);
      bus.stage_ack    = 3'($urandom_range(0, 7));
      bus.sw_reset_req = ($urandom_range(0, 49) == 0);
      tick(1);
      r  = bus.reset_out;
      ok = 1'b1;
      for (int i = 1; i < 3; i++) begin
        for (int j = 0; j < i; j++) begin
          if (!r[i] && r[j]) ok = 1'b0;
        end
      end
      if (bus.seq_done && r != 3'b000) ok = 1'b0;
      if (bus.seq_error && r != 3'b111) ok = 1'b0;
      if (bus.seq_done && bus.seq_error) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_order cycle=%0d: got rst=%b done=%b err=%b, required ordered release and consistent flags",
                 c, r, bus.seq_done, bus.seq_error);
      end
    end
    bus.sw_reset_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
